// File: rtl/memoria_arbitro_if.sv
// memoria_arbitro_if: bundle of the requester and memory-side signals of the
// three-port memory arbiter.
//   master : environment side (requesters drive req/wr/addr/din and clone
//            controls, the memory drives mem_dato)
//   slave  : arbiter side (drives grants, read data and the memory port)
interface memoria_arbitro_if;
  logic       req0, req1, req2;
  logic       wr0, wr1, wr2;
  logic [3:0] addr0, addr1, addr2;
  logic [7:0] din0, din1, din2;
  logic       gnt0, gnt1, gnt2;
  logic       rvalid0, rvalid1, rvalid2;
  logic [7:0] rdata;
  logic       clone_req;
  logic       clone_dir;
  logic       clone_busy;
  logic [3:0] mem_add;
  logic [7:0] mem_dat;
  logic       mem_w;
  logic       mem_r;
  logic [2:0] mem_flags;
  logic [7:0] mem_dato;

  modport master (
    output req0, req1, req2, wr0, wr1, wr2, addr0, addr1, addr2,
           din0, din1, din2, clone_req, clone_dir, mem_dato,
    input  gnt0, gnt1, gnt2, rvalid0, rvalid1, rvalid2, rdata,
           clone_busy, mem_add, mem_dat, mem_w, mem_r, mem_flags
  );

  modport slave (
    input  req0, req1, req2, wr0, wr1, wr2, addr0, addr1, addr2,
           din0, din1, din2, clone_req, clone_dir, mem_dato,
    output gnt0, gnt1, gnt2, rvalid0, rvalid1, rvalid2, rdata,
           clone_busy, mem_add, mem_dat, mem_w, mem_r, mem_flags
  );
endinterface

// File: rtl/memoria_arbitro.sv
// memoria_arbitro: round-robin arbiter giving three requesters access to one
// single-port memory, plus a bank-clone command path with priority over them.
//   clk       : single clock, rising edge
//   reset     : asynchronous, active-low
//   bus       : memoria_arbitro_if.slave
//     req/wr/addr/din N  -> request, direction, address, write data
//     gnt N / rvalid N   <- one-cycle grant / read-valid pulses
//     rdata              <- read data, valid while an rvalid is high
//     clone_req/dir      -> clone request and direction
//     clone_busy         <- clone sequence in progress
//     mem_add/dat/w/r    <- memory access port
//     mem_flags          <- clone command (3'b010 bank1->2, 3'b001 bank2->1)
//     mem_dato           -> memory read data, one cycle after mem_r
module memoria_arbitro #(
  parameter int CLONE_CYC = 2
) (
  input logic               clk,
  input logic               reset,
  memoria_arbitro_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ACCESS     = 3'd1,
    READ_WAIT  = 3'd2,
    CLONE      = 3'd3,
    CLONE_WAIT = 3'd4
  } state_t;

  localparam int CW = (CLONE_CYC > 1) ? $clog2(CLONE_CYC) : 1;

  // Round-robin pick: returns {found, index}, search starts after last.
  function automatic logic [2:0] rr_pick(input logic [1:0] last,
                                         input logic [2:0] req);
    logic [2:0] res;
    res = 3'b000;
    case (last)
      2'd0: begin
        if (req[1])      res = {1'b1, 2'd1};
        else if (req[2]) res = {1'b1, 2'd2};
        else if (req[0]) res = {1'b1, 2'd0};
        else             res = 3'b000;
      end
      2'd1: begin
        if (req[2])      res = {1'b1, 2'd2};
        else if (req[0]) res = {1'b1, 2'd0};
        else if (req[1]) res = {1'b1, 2'd1};
        else             res = 3'b000;
      end
      default: begin
        if (req[0])      res = {1'b1, 2'd0};
        else if (req[1]) res = {1'b1, 2'd1};
        else if (req[2]) res = {1'b1, 2'd2};
        else             res = 3'b000;
      end
    endcase
    return res;
  endfunction

  state_t        state_r;
  logic [1:0]    last_r;
  logic [1:0]    win_r;
  logic          wr_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    gnt_r;
  logic [2:0]    rvalid_r;
  logic          mem_w_r;
  logic          mem_r_r;
  logic [3:0]    mem_add_r;
  logic [7:0]    mem_dat_r;
  logic [2:0]    mem_flags_r;
  logic          busy_r;

  logic [2:0]    pick_s;
  logic          sel_wr_s;
  logic [3:0]    sel_addr_s;
  logic [7:0]    sel_din_s;

  assign pick_s = rr_pick(last_r, {bus.req2, bus.req1, bus.req0});

  // Route the candidate winner's request fields for latching.
  always_comb begin
    sel_wr_s   = 1'b0;
    sel_addr_s = 4'h0;
    sel_din_s  = 8'h00;
    case (pick_s[1:0])
      2'd0: begin
        sel_wr_s   = bus.wr0;
        sel_addr_s = bus.addr0;
        sel_din_s  = bus.din0;
      end
      2'd1: begin
        sel_wr_s   = bus.wr1;
        sel_addr_s = bus.addr1;
        sel_din_s  = bus.din1;
      end
      2'd2: begin
        sel_wr_s   = bus.wr2;
        sel_addr_s = bus.addr2;
        sel_din_s  = bus.din2;
      end
      default: begin
        sel_wr_s   = 1'b0;
        sel_addr_s = 4'h0;
        sel_din_s  = 8'h00;
      end
    endcase
  end

  // Control FSM. Outputs are registered on the transition into the state in
  // which they must be visible, so they line up exactly with that state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      last_r      <= 2'd2;
      win_r       <= 2'd0;
      wr_r        <= 1'b0;
      cnt_r       <= '0;
      gnt_r       <= 3'b000;
      rvalid_r    <= 3'b000;
      mem_w_r     <= 1'b0;
      mem_r_r     <= 1'b0;
      mem_add_r   <= 4'h0;
      mem_dat_r   <= 8'h00;
      mem_flags_r <= 3'b000;
      busy_r      <= 1'b0;
    end else begin
      gnt_r       <= 3'b000;
      rvalid_r    <= 3'b000;
      mem_w_r     <= 1'b0;
      mem_r_r     <= 1'b0;
      mem_add_r   <= 4'h0;
      mem_dat_r   <= 8'h00;
      mem_flags_r <= 3'b000;
      busy_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.clone_req) begin
            // The flags register doubles as the latched clone direction.
            mem_flags_r <= bus.clone_dir ? 3'b001 : 3'b010;
            busy_r      <= 1'b1;
            state_r     <= CLONE;
          end else if (pick_s[2]) begin
            win_r     <= pick_s[1:0];
            last_r    <= pick_s[1:0];
            wr_r      <= sel_wr_s;
            gnt_r     <= 3'b001 << pick_s[1:0];
            mem_w_r   <= sel_wr_s;
            mem_r_r   <= ~sel_wr_s;
            mem_add_r <= sel_addr_s;
            mem_dat_r <= sel_din_s;
            state_r   <= ACCESS;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          if (wr_r) begin
            state_r <= IDLE;
          end else begin
            rvalid_r <= 3'b001 << win_r;
            state_r  <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          state_r <= IDLE;
        end
        CLONE: begin
          cnt_r <= '0;
          if (CLONE_CYC == 0) begin
            state_r <= IDLE;
          end else begin
            busy_r  <= 1'b1;
            state_r <= CLONE_WAIT;
          end
        end
        CLONE_WAIT: begin
          if (cnt_r == CW'(CLONE_CYC - 1)) begin
            state_r <= IDLE;
          end else begin
            cnt_r   <= cnt_r + CW'(1);
            busy_r  <= 1'b1;
            state_r <= CLONE_WAIT;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0       = gnt_r[0];
  assign bus.gnt1       = gnt_r[1];
  assign bus.gnt2       = gnt_r[2];
  assign bus.rvalid0    = rvalid_r[0];
  assign bus.rvalid1    = rvalid_r[1];
  assign bus.rvalid2    = rvalid_r[2];
  assign bus.mem_w      = mem_w_r;
  assign bus.mem_r      = mem_r_r;
  assign bus.mem_add    = mem_add_r;
  assign bus.mem_dat    = mem_dat_r;
  assign bus.mem_flags  = mem_flags_r;
  assign bus.clone_busy = busy_r;
  // Memory data arrives during READ_WAIT itself, so it is passed through,
  // gated by the registered rvalid so rdata is zero at all other times.
  assign bus.rdata      = (|rvalid_r) ? bus.mem_dato : 8'h00;

endmodule

// File: tb/tb_memoria_arbitro.sv
// tb_memoria_arbitro: directed, table-driven bench for memoria_arbitro with a
// small synchronous memory model and a per-cycle invariant monitor.
module tb_memoria_arbitro;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  memoria_arbitro_if bus();
  memoria_arbitro #(.CLONE_CYC(2)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Memory model: synchronous write, read data one cycle after mem_r.
  logic [7:0] mem [16];
  logic [7:0] mem_q;
  always @(posedge clk) begin
    if (bus.mem_w) mem[bus.mem_add] <= bus.mem_dat;
    if (bus.mem_r) mem_q <= mem[bus.mem_add];
  end
  assign bus.mem_dato = mem_q;

  logic [2:0] gnt, rv;
  assign gnt = {bus.gnt2, bus.gnt1, bus.gnt0};
  assign rv  = {bus.rvalid2, bus.rvalid1, bus.rvalid0};

  // Invariants every cycle.
  always @(negedge clk) begin
    total++;
    if ((bus.mem_w && bus.mem_r) || ($countones(gnt) > 1) ||
        ($countones(rv) > 1) || ((bus.mem_flags != 3'b000) && !bus.clone_busy)) begin
      bad++;
      $display("FAIL invariant: gnt=%b rvalid=%b mem_w=%b mem_r=%b flags=%b busy=%b",
               gnt, rv, bus.mem_w, bus.mem_r, bus.mem_flags, bus.clone_busy);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.req2 = 1'b0;
    bus.wr0 = 1'b0;  bus.wr1 = 1'b0;  bus.wr2 = 1'b0;
    bus.addr0 = 4'h0; bus.addr1 = 4'h0; bus.addr2 = 4'h0;
    bus.din0 = 8'h00; bus.din1 = 8'h00; bus.din2 = 8'h00;
    bus.clone_req = 1'b0; bus.clone_dir = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " gnt"}, 32'(gnt), 32'd0);
    check({tag, " rvalid"}, 32'(rv), 32'd0);
    check({tag, " mem_w/r"}, {30'd0, bus.mem_w, bus.mem_r}, 32'd0);
    check({tag, " busy"}, 32'(bus.clone_busy), 32'd0);
    check({tag, " flags"}, 32'(bus.mem_flags), 32'd0);
    check({tag, " mem_add"}, 32'(bus.mem_add), 32'd0);
    check({tag, " mem_dat"}, 32'(bus.mem_dat), 32'd0);
    check({tag, " rdata"}, 32'(bus.rdata), 32'd0);
  endtask

  typedef struct {
    logic [2:0] req;
    logic [2:0] wr;
    logic [3:0] a0, a1, a2;
    logic [7:0] d0, d1, d2;
    logic [2:0] egnt;
    logic       ewr;
    logic [3:0] eadd;
    logic [7:0] edat;
    logic [7:0] erd;
  } vec_t;

  vec_t tab [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants, last_cyc, cyc, g1_seen, g0_seen;
    logic [2:0] f_exp;

    //          req     wr      a0    a1    a2    d0     d1     d2     egnt   ewr   eadd  edat   erd
    tab[0] = '{3'b001, 3'b001, 4'd5, 4'd0, 4'd0, 8'h5A, 8'h00, 8'h00, 3'b001, 1'b1, 4'd5, 8'h5A, 8'h00};
    tab[1] = '{3'b001, 3'b000, 4'd5, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 3'b001, 1'b0, 4'd5, 8'h00, 8'h5A};
    tab[2] = '{3'b111, 3'b111, 4'd1, 4'd3, 4'd7, 8'h11, 8'hC3, 8'h77, 3'b010, 1'b1, 4'd3, 8'hC3, 8'h00};
    tab[3] = '{3'b101, 3'b101, 4'd2, 4'd0, 4'd9, 8'h22, 8'h00, 8'h99, 3'b100, 1'b1, 4'd9, 8'h99, 8'h00};
    tab[4] = '{3'b110, 3'b000, 4'd0, 4'd3, 4'd9, 8'h00, 8'h00, 8'h00, 3'b010, 1'b0, 4'd3, 8'h00, 8'hC3};
    tab[5] = '{3'b011, 3'b000, 4'd5, 4'd3, 4'd0, 8'h00, 8'h00, 8'h00, 3'b001, 1'b0, 4'd5, 8'h00, 8'h5A};
    tab[6] = '{3'b100, 3'b000, 4'd0, 4'd0, 4'd9, 8'h00, 8'h00, 8'h00, 3'b100, 1'b0, 4'd9, 8'h00, 8'h99};
    tab[7] = '{3'b110, 3'b110, 4'd0, 4'd15, 4'd0, 8'h00, 8'hFF, 8'h01, 3'b010, 1'b1, 4'd15, 8'hFF, 8'h00};
    tab[8] = '{3'b101, 3'b000, 4'd0, 4'd0, 4'd15, 8'h00, 8'h00, 8'h00, 3'b100, 1'b0, 4'd15, 8'h00, 8'hFF};

    clear_inputs();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    tick();
    check_all_zero("idle after reset");

    // Table-driven accesses; round-robin history carries from one row to the next.
    for (int i = 0; i < 9; i++) begin
      {bus.req2, bus.req1, bus.req0} = tab[i].req;
      {bus.wr2, bus.wr1, bus.wr0}    = tab[i].wr;
      bus.addr0 = tab[i].a0; bus.addr1 = tab[i].a1; bus.addr2 = tab[i].a2;
      bus.din0 = tab[i].d0;  bus.din1 = tab[i].d1;  bus.din2 = tab[i].d2;
      tick();
      check($sformatf("v%0d gnt", i), 32'(gnt), 32'(tab[i].egnt));
      check($sformatf("v%0d mem_w", i), 32'(bus.mem_w), 32'(tab[i].ewr));
      check($sformatf("v%0d mem_r", i), 32'(bus.mem_r), 32'(!tab[i].ewr));
      check($sformatf("v%0d mem_add", i), 32'(bus.mem_add), 32'(tab[i].eadd));
      check($sformatf("v%0d mem_dat", i), 32'(bus.mem_dat), 32'(tab[i].edat));
      check($sformatf("v%0d rvalid in access", i), 32'(rv), 32'd0);
      clear_inputs();
      if (!tab[i].ewr) begin
        tick();
        check($sformatf("v%0d rvalid", i), 32'(rv), 32'(tab[i].egnt));
        check($sformatf("v%0d rdata", i), 32'(bus.rdata), 32'(tab[i].erd));
        check($sformatf("v%0d gnt in read_wait", i), 32'(gnt), 32'd0);
      end
      tick();
      check($sformatf("v%0d idle gnt", i), 32'(gnt), 32'd0);
      check($sformatf("v%0d idle rvalid", i), 32'(rv), 32'd0);
    end

    // All three requesters held high after a fresh reset: 0,1,2,0,1,2, 3 cycles apart.
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.req2 = 1'b1;
    grants = 0; last_cyc = 0; cyc = 0;
    while (grants < 6 && cyc < 40) begin
      tick();
      cyc++;
      if (gnt != 3'b000) begin
        check($sformatf("rr grant %0d", grants), 32'(gnt), 32'(3'b001 << (grants % 3)));
        if (grants > 0) check($sformatf("rr gap %0d", grants), 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        grants++;
      end
    end
    check("rr grant count", 32'(grants), 32'd6);
    clear_inputs();
    tick(); tick();

    // Clone together with req1: clone first, busy 3 cycles, then gnt1.
    for (int d = 0; d < 2; d++) begin
      f_exp = (d == 0) ? 3'b010 : 3'b001;
      bus.clone_req = 1'b1; bus.clone_dir = d[0];
      bus.req1 = 1'b1; bus.wr1 = 1'b1; bus.addr1 = 4'd4; bus.din1 = 8'h44;
      tick();
      check($sformatf("clone%0d flags", d), 32'(bus.mem_flags), 32'(f_exp));
      check($sformatf("clone%0d busy c0", d), 32'(bus.clone_busy), 32'd1);
      check($sformatf("clone%0d gnt c0", d), 32'(gnt), 32'd0);
      bus.clone_req = 1'b0;
      for (int c = 1; c < 3; c++) begin
        tick();
        check($sformatf("clone%0d busy c%0d", d, c), 32'(bus.clone_busy), 32'd1);
        check($sformatf("clone%0d flags c%0d", d, c), 32'(bus.mem_flags), 32'd0);
      end
      tick();
      check($sformatf("clone%0d busy end", d), 32'(bus.clone_busy), 32'd0);
      check($sformatf("clone%0d gnt idle", d), 32'(gnt), 32'd0);
      tick();
      check($sformatf("clone%0d gnt1", d), 32'(gnt), 32'b010);
      clear_inputs();
      tick();
    end

    // Clone raised during ACCESS is served before the pending req0;
    // a one-cycle req1 pulse during the clone is never granted.
    bus.req2 = 1'b1; bus.wr2 = 1'b1; bus.addr2 = 4'd6; bus.din2 = 8'h66;
    tick();
    check("mid gnt2", 32'(gnt), 32'b100);
    clear_inputs();
    bus.clone_req = 1'b1;
    bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 4'd8; bus.din0 = 8'h88;
    tick();
    check("mid idle gnt", 32'(gnt), 32'd0);
    tick();
    check("mid clone flags", 32'(bus.mem_flags), 32'b010);
    check("mid clone gnt", 32'(gnt), 32'd0);
    bus.clone_req = 1'b0;
    bus.req1 = 1'b1; bus.wr1 = 1'b1;
    tick();
    bus.req1 = 1'b0;
    g1_seen = 0; g0_seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.gnt1) g1_seen++;
      if (bus.gnt0) begin
        g0_seen++;
        bus.req0 = 1'b0;
      end
    end
    check("pulsed req1 grants", 32'(g1_seen), 32'd0);
    check("held req0 grants", 32'(g0_seen), 32'd1);
    clear_inputs();

    // Reset mid-READ_WAIT: outputs clear at once and no rvalid follows.
    bus.req0 = 1'b1; bus.addr0 = 4'd5;
    tick();
    check("rst read gnt0", 32'(gnt), 32'b001);
    clear_inputs();
    tick();
    check("rst read rvalid before reset", 32'(rv), 32'b001);
    #2 reset = 1'b0;
    #1 check_all_zero("async reset");
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("post reset rvalid %0d", c), 32'(rv), 32'd0);
    end
    bus.req2 = 1'b1; bus.wr2 = 1'b1; bus.addr2 = 4'd3; bus.din2 = 8'h33;
    tick();
    check("post reset gnt2", 32'(gnt), 32'b100);
    check("post reset mem_dat", 32'(bus.mem_dat), 32'h33);
    clear_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
